fetch_unit: RTL and testbench

- Instruction fetch front end for the OoO core.
- Acts as the initiator for the combinational instruction ROM: drives the word-aligned byte address and captures the returned instruction word.
- Buffers {pc, instruction} pairs in a small FIFO and feeds decode over a valid/ready interface.
- Accepts redirects (branch resolution / mispredict recovery) that flush the queue and restart fetch at a new PC.

---
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch front end. Reads a combinational ROM, queues
//            {pc, instruction} pairs and hands them to decode (valid/ready).
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 1024,
  parameter int          QDEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [31:0]                imem_address,
  input  logic [31:0]                imem_instruction,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instruction,
  output logic                       fetch_done,
  output logic                       misalign_err,
  output logic [$clog2(QDEPTH):0]    q_count
);

  localparam int              AW        = $clog2(QDEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [32:0]     MEM_LIMIT = 33'(MEM_SIZE);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(QDEPTH);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_END   = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     pc;
  logic [31:0]     pc_next;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_adv;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [31:0]     q_pc  [QDEPTH];
  logic [31:0]     q_ins [QDEPTH];

  logic            in_bounds;
  logic            handshake;
  logic            pop;
  logic            push_ok;
  logic            push;
  logic            head_load;
  logic [31:0]     head_pc_next;
  logic [31:0]     head_ins_next;

  assign imem_address = pc;
  assign out_valid    = (count != '0);
  assign q_count      = count;
  assign fetch_done   = (state == S_END);

  // Bounds check is done in 33 bits so a PC near 2^32 cannot wrap into range.
  assign in_bounds = (({1'b0, pc} + 33'd3) < MEM_LIMIT);
  assign handshake = out_valid && out_ready;
  assign pop       = handshake && !redirect_valid;
  assign push_ok   = (count < DEPTH_C) || handshake;
  assign push      = (state == S_FETCH) && !redirect_valid && in_bounds && push_ok;
  assign rd_adv    = pop ? (rd_ptr + PTR_ONE) : rd_ptr;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_valid) begin
      state_next = S_FETCH;
      pc_next    = {redirect_pc[31:2], 2'b00};
    end else begin
      case (state)
        S_FETCH: begin
          if (!in_bounds) begin
            state_next = S_END;
          end else if (push) begin
            pc_next = pc + 32'd4;
          end
        end
        S_END:   state_next = S_END;
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_comb begin
    count_next = count;
    if (redirect_valid) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  // The head registers follow the entry that will sit at rd_adv after the
  // edge; when that slot is the one being written this cycle, bypass it.
  always_comb begin
    head_load     = (count_next != '0);
    head_pc_next  = q_pc[rd_adv];
    head_ins_next = q_ins[rd_adv];
    if (push && (rd_adv == wr_ptr)) begin
      head_pc_next  = pc;
      head_ins_next = imem_instruction;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_adv;
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]  <= '0;
        q_ins[i] <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]  <= pc;
      q_ins[wr_ptr] <= imem_instruction;
    end
  end

  // Outputs hold the last head while the queue is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_pc          <= '0;
      out_instruction <= '0;
    end else if (head_load) begin
      out_pc          <= head_pc_next;
      out_instruction <= head_ins_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit using a {pc, instr} scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        fetch_done;
  logic        misalign_err;
  logic [2:0]  q_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(1024), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_address(imem_address), .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instruction(out_instruction),
    .fetch_done(fetch_done), .misalign_err(misalign_err), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    case (idx)
      8'd0:    return 32'h0000_0013;
      8'd1:    return 32'h0010_0093;
      8'd2:    return 32'h0020_0113;
      8'd3:    return 32'h0030_0193;
      default: return 32'hA500_0013 | ({24'h0, idx} << 8);
    endcase
  endfunction

  assign imem_instruction = (imem_address < 32'd1024) ? rom_word(imem_address) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_pc(input logic [31:0] a);
    sb.push_back({a, rom_word(a)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [63:0] e;
    out_ready = 1'b0;
    reset = 1'b1;
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, q_count, fetch_done, misalign_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got valid=%b cnt=%0d done=%b mis=%b, want 0/0/0/0",
               out_valid, q_count, fetch_done, misalign_err);
    end
    n_cmp++;
    if ({out_pc, out_instruction, imem_address} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_regs: got pc=%h ins=%h addr=%h, want all 0", out_pc, out_instruction, imem_address);
    end
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_valid: got %b want 0", out_valid);
    end
    expect_pc(32'h0);
    tick();
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({out_valid, out_pc, out_instruction} !== {1'b1, e}) begin
      n_bad++;
      $display("FAIL reset_first_fetch: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
               out_valid, out_pc, out_instruction, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_stream();
    logic [63:0] e;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({out_valid, out_pc, out_instruction} !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL stream[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 i, out_valid, out_pc, out_instruction, e[63:32], e[31:0]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    out_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    n_cmp++;
    if ({q_count, imem_address} !== {3'd4, 32'd16}) begin
      n_bad++;
      $display("FAIL bp_full: got cnt=%0d addr=%h want cnt=4 addr=00000010", q_count, imem_address);
    end
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if ({out_pc, out_instruction} !== e) begin
          n_bad++;
          $display("FAIL bp_drain: got pc=%h ins=%h want pc=%h ins=%h",
                   out_pc, out_instruction, e[63:32], e[31:0]);
        end
      end
      tick();
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL bp_timeout: got %0d entries undelivered want 0", sb.size());
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, q_count} !== 4'b0) begin
      n_bad++;
      $display("FAIL redir_flush: got v=%b cnt=%0d want v=0 cnt=0", out_valid, q_count);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_pc, out_instruction, misalign_err} !== {1'b1, 32'h40, rom_word(32'h40), 1'b0}) begin
      n_bad++;
      $display("FAIL redir_target: got v=%b pc=%h ins=%h mis=%b want v=1 pc=00000040 ins=%h mis=0",
               out_valid, out_pc, out_instruction, misalign_err, rom_word(32'h40));
    end
  endtask

  task automatic test_misalign();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_pc, misalign_err} !== {1'b1, 32'h40, 1'b1}) begin
      n_bad++;
      $display("FAIL misalign_set: got v=%b pc=%h mis=%b want v=1 pc=00000040 mis=1",
               out_valid, out_pc, misalign_err);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({out_pc, out_instruction, misalign_err} !== {32'h80, rom_word(32'h80), 1'b1}) begin
      n_bad++;
      $display("FAIL misalign_sticky: got pc=%h ins=%h mis=%b want pc=00000080 mis=1",
               out_pc, out_instruction, misalign_err);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (misalign_err !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_clear: got %b want 0", misalign_err);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_end_of_mem();
    logic [63:0] e;
    out_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h3F8;
    tick();
    redirect_valid = 1'b0;
    expect_pc(32'h3F8);
    expect_pc(32'h3FC);
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if ({out_pc, out_instruction} !== e) begin
          n_bad++;
          $display("FAIL end_stream: got pc=%h ins=%h want pc=%h ins=%h",
                   out_pc, out_instruction, e[63:32], e[31:0]);
        end
      end
      tick();
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL end_timeout: got %0d undelivered want 0", sb.size());
    end
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({fetch_done, imem_address, out_valid} !== {1'b1, 32'h400, 1'b0}) begin
      n_bad++;
      $display("FAIL end_idle: got done=%b addr=%h v=%b want done=1 addr=00000400 v=0",
               fetch_done, imem_address, out_valid);
    end
    // Redirect to an out-of-range target: FETCH for one cycle, then END, no push.
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (fetch_done !== 1'b0) begin
      n_bad++;
      $display("FAIL oob_enter_fetch: got done=%b want 0", fetch_done);
    end
    tick();
    n_cmp++;
    if ({fetch_done, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL oob_to_end: got done=%b v=%b want done=1 v=0", fetch_done, out_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (fetch_done !== 1'b0) begin
      n_bad++;
      $display("FAIL end_exit: got done=%b want 0", fetch_done);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h0, rom_word(32'h0)}) begin
      n_bad++;
      $display("FAIL end_restart: got v=%b pc=%h ins=%h want v=1 pc=00000000 ins=%h",
               out_valid, out_pc, out_instruction, rom_word(32'h0));
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h3F4;
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if ({q_count, fetch_done} !== {3'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL async_setup: got cnt=%0d done=%b want cnt=3 done=1", q_count, fetch_done);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, q_count, fetch_done} !== 5'b0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b cnt=%0d done=%b want all 0", out_valid, q_count, fetch_done);
    end
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_pc} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL async_restart: got v=%b pc=%h want v=1 pc=00000000", out_valid, out_pc);
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_end_of_mem();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
